frame_backup_stack: RTL

FRAME_BACKUP_STACK -- requirements
Module: frame_backup_stack

---
 rtl/fbs_pkg.sv | 19 +
 rtl/fbs_stack_mem.sv | 29 ++
 rtl/frame_backup_stack.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fbs_pkg.sv
// Shared defaults and operation encoding for the frame backup stack.
package fbs_pkg;

  localparam int unsigned FBS_DATA_W = 256;
  localparam int unsigned FBS_DEPTH  = 16;

  // Operation selected by {restore, backup}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_SWAP = 2'b11
  } fbs_op_e;

  function automatic fbs_op_e fbs_decode(input logic backup, input logic restore);
    return fbs_op_e'({restore, backup});
  endfunction

endpackage

// File: rtl/fbs_stack_mem.sv
// Frame storage: DEPTH x DATA_W, one synchronous write port, one synchronous
// read port. A read and write to the same index return the old contents.
// Contents are never reset.
module fbs_stack_mem #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port and registered read port; both nonblocking so a same-index read sees the old frame.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_backup_stack.sv
// LIFO of register frames with push (backup), pop (restore) and swap.
// Pointer, error flags, op decode and output qualification live here;
// storage is in fbs_stack_mem.
module frame_backup_stack
  import fbs_pkg::*;
#(
  parameter int unsigned DATA_W = FBS_DATA_W,
  parameter int unsigned DEPTH  = FBS_DEPTH,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              backup,
  input  logic              restore,
  input  logic              clear_err,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              restore_valid,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              overflow_err,
  output logic              underflow_err
);

  logic [PTR_W:0]    r_sp;
  logic              r_valid;
  logic              r_ovf;
  logic              r_unf;
  logic              r_out_zero;

  fbs_op_e           w_op;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W-1:0]  w_top_idx;
  logic [PTR_W-1:0]  w_push_idx;
  logic [PTR_W:0]    w_sp_nxt;
  logic              w_we;
  logic [PTR_W-1:0]  w_waddr;
  logic              w_re;
  logic              w_valid_nxt;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic [DATA_W-1:0] w_rd_data;

  assign w_op       = fbs_decode(backup, restore);
  assign w_full     = (r_sp == (PTR_W+1)'(DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_top_idx  = PTR_W'(r_sp - (PTR_W+1)'(1));
  assign w_push_idx = r_sp[PTR_W-1:0];

  // Decode the requested operation against the current fill level.
  always_comb begin
    w_sp_nxt    = r_sp;
    w_we        = 1'b0;
    w_waddr     = w_push_idx;
    w_re        = 1'b0;
    w_valid_nxt = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    unique case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_we     = 1'b1;
          w_sp_nxt = r_sp + (PTR_W+1)'(1);
        end else begin
          w_ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (!w_empty) begin
          w_re        = 1'b1;
          w_valid_nxt = 1'b1;
          w_sp_nxt    = r_sp - (PTR_W+1)'(1);
        end else begin
          w_unf_set = 1'b1;
        end
      end
      OP_SWAP: begin
        if (!w_empty) begin
          // Read and overwrite the top slot in the same cycle; memory returns the old frame.
          w_re        = 1'b1;
          w_we        = 1'b1;
          w_waddr     = w_top_idx;
          w_valid_nxt = 1'b1;
        end else begin
          // Empty stack: the backup half still lands, the restore half is an underflow.
          w_we      = 1'b1;
          w_sp_nxt  = r_sp + (PTR_W+1)'(1);
          w_unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pointer, valid and sticky error flags; error events take priority over clear_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp       <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_out_zero <= 1'b1;
    end else begin
      r_sp    <= w_sp_nxt;
      r_valid <= w_valid_nxt;
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (clear_err) r_ovf <= 1'b0;
      if (w_unf_set)      r_unf <= 1'b1;
      else if (clear_err) r_unf <= 1'b0;
      if (w_re)           r_out_zero <= 1'b0;
    end
  end

  // The memory read register is the data_out register; it only loads on a pop
  // (gated by reset), and is masked to zero from reset until the first pop.
  fbs_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we && rst_n),
    .i_waddr (w_waddr),
    .i_wdata (data_in),
    .i_re    (w_re && rst_n),
    .i_raddr (w_top_idx),
    .o_rdata (w_rd_data)
  );

  assign data_out      = r_out_zero ? '0 : w_rd_data;
  assign restore_valid = r_valid;
  assign count         = r_sp;
  assign full          = w_full;
  assign empty         = w_empty;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule
